// File: rtl/chimera_clu_clkgate_seq.sv
// Per-cluster clock-gate / AXI-isolation sequencer: OFF -> SETTLE -> ON -> ISOLATE -> OFF.
// Optional drain timeout guarded by macro CHIMERA_CLKGATE_TIMEOUT_EN.
module chimera_clu_clkgate_seq #(
    parameter int unsigned ExtClusters  = 5,
    parameter int unsigned SettleCycles = 4,
    parameter int unsigned DrainTimeout = 255
) (
    input  logic                     soc_clk_i,
    input  logic                     rst_i,
    input  logic [ExtClusters-1:0]   en_req_i,
    input  logic [ExtClusters-1:0]   busy_i,
    input  logic [ExtClusters-1:0]   err_clr_i,
    output logic [ExtClusters-1:0]   clk_en_o,
    output logic [ExtClusters-1:0]   isolate_o,
    output logic [ExtClusters-1:0]   active_o,
    output logic [ExtClusters-1:0]   err_o,
    output logic [2*ExtClusters-1:0] dbg_state_o
);

    localparam logic [1:0] ST_OFF     = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_ON      = 2'd2;
    localparam logic [1:0] ST_ISOLATE = 2'd3;

    localparam logic [7:0] SETTLE_LOAD = 8'(SettleCycles - 1);

`ifdef CHIMERA_CLKGATE_TIMEOUT_EN
    localparam logic [15:0] DRAIN_MAX = 16'(DrainTimeout);
`else
    logic unused_err_clr;
    assign unused_err_clr = ^err_clr_i;
`endif

    for (genvar c = 0; c < ExtClusters; c++) begin : g_chan
        logic [1:0] state_q, state_d;
        logic [7:0] settle_q, settle_d;
        logic       first_q, first_d;
        logic       drain_hit;
        logic       err_set;
        logic       clk_en_q, isolate_q, active_q;

        always_comb begin
            state_d  = state_q;
            settle_d = settle_q;
            first_d  = 1'b0;
            err_set  = 1'b0;
            case (state_q)
                ST_OFF: begin
                    if (en_req_i[c]) begin
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (!en_req_i[c]) begin
                        state_d  = ST_OFF;
                        settle_d = 8'd0;
                    end else if (settle_q == 8'd0) begin
                        state_d = ST_ON;
                    end else begin
                        settle_d = settle_q - 8'd1;
                    end
                end
                ST_ON: begin
                    if (!en_req_i[c]) begin
                        state_d = ST_ISOLATE;
                        first_d = 1'b1;
                    end
                end
                default: begin
                    // Abort beats drain completion; busy_i is not trusted in the entry cycle.
                    if (en_req_i[c]) begin
                        state_d = ST_ON;
                    end else if (!first_q && !busy_i[c]) begin
                        state_d = ST_OFF;
                    end else if (drain_hit) begin
                        state_d = ST_ON;
                        err_set = 1'b1;
                    end
                end
            endcase
        end

        always_ff @(posedge soc_clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q   <= ST_OFF;
                settle_q  <= 8'd0;
                first_q   <= 1'b0;
                clk_en_q  <= 1'b0;
                isolate_q <= 1'b1;
                active_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                settle_q  <= settle_d;
                first_q   <= first_d;
                clk_en_q  <= (state_d != ST_OFF);
                isolate_q <= (state_d != ST_ON);
                active_q  <= (state_d == ST_ON);
            end
        end

`ifdef CHIMERA_CLKGATE_TIMEOUT_EN
        logic [15:0] drain_q;
        logic        err_q;

        assign drain_hit = busy_i[c] && (drain_q == DRAIN_MAX);

        // Counts ISOLATE cycles starting at 1 on entry; saturates instead of wrapping.
        always_ff @(posedge soc_clk_i or posedge rst_i) begin
            if (rst_i) begin
                drain_q <= 16'd0;
                err_q   <= 1'b0;
            end else begin
                if (state_q != ST_ISOLATE && state_d == ST_ISOLATE) begin
                    drain_q <= 16'd1;
                end else if (state_q == ST_ISOLATE && drain_q != 16'hffff) begin
                    drain_q <= drain_q + 16'd1;
                end
                err_q <= err_set | (err_q & ~err_clr_i[c]);
            end
        end

        assign err_o[c] = err_q;
`else
        logic unused_err_set;
        assign drain_hit      = 1'b0;
        assign unused_err_set = err_set;
        assign err_o[c]       = 1'b0;
`endif

        assign clk_en_o[c]          = clk_en_q;
        assign isolate_o[c]         = isolate_q;
        assign active_o[c]          = active_q;
        assign dbg_state_o[2*c +: 2] = state_q;
    end

endmodule

// File: tb/tb_chimera_clu_clkgate_seq.sv
// Directed bench for chimera_clu_clkgate_seq (5 clusters, SettleCycles=4, DrainTimeout=16).
module tb_chimera_clu_clkgate_seq;

    logic       clk;
    logic       rst;
    logic [4:0] en_req;
    logic [4:0] busy;
    logic [4:0] err_clr;
    logic [4:0] clk_en;
    logic [4:0] isolate;
    logic [4:0] active;
    logic [4:0] err;
    logic [9:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    chimera_clu_clkgate_seq #(
        .ExtClusters (5),
        .SettleCycles(4),
        .DrainTimeout(16)
    ) dut (
        .soc_clk_i  (clk),
        .rst_i      (rst),
        .en_req_i   (en_req),
        .busy_i     (busy),
        .err_clr_i  (err_clr),
        .clk_en_o   (clk_en),
        .isolate_o  (isolate),
        .active_o   (active),
        .err_o      (err),
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Gating order monitor: clk_en may only fall with isolation held, isolation may only drop with clock running.
    logic [4:0] prev_clk_en = 5'b00000;
    logic [4:0] prev_iso    = 5'b11111;
    always @(negedge clk) begin
        n_vec++;
        assert (((prev_clk_en & ~clk_en & ~isolate) | (prev_iso & ~isolate & ~clk_en)) === 5'b00000) else begin
            n_err++;
            $error("FAIL order: clk_en %0h->%0h isolate %0h->%0h", prev_clk_en, clk_en, prev_iso, isolate);
        end
        prev_clk_en = clk_en;
        prev_iso    = isolate;
    end

    logic [4:0] exp_iso, exp_act, exp_err;

    initial begin
        rst = 1'b1; en_req = '0; busy = '0; err_clr = '0;
        step(2);
        chk("rst_clk_en", 10'(clk_en), 10'h000);
        chk("rst_iso", 10'(isolate), 10'h01f);
        chk("rst_act", 10'(active), 10'h000);
        chk("rst_err", 10'(err), 10'h000);
        rst = 1'b0;
        step(3);
        chk("idle_clk_en", 10'(clk_en), 10'h000);
        chk("idle_state", dbg_state, 10'h000);

        // Channel 0 power-up through SETTLE
        en_req = 5'b00001;
        step(1);
        chk("a_clk_en", 10'(clk_en), 10'h001);
        chk("a_iso_settle", 10'(isolate), 10'h01f);
        step(3);
        chk("a_iso_settle_end", 10'(isolate), 10'h01f);
        chk("a_act_settle_end", 10'(active), 10'h000);
        step(1);
        chk("a_iso_on", 10'(isolate), 10'h01e);
        chk("a_act_on", 10'(active), 10'h001);
        chk("a_clk_en_on", 10'(clk_en), 10'h001);
        chk("a_state_on", dbg_state, 10'h002);

        // Channel 1 power-down with busy held for five edges
        en_req = 5'b00011;
        step(5);
        chk("b_act_on", 10'(active), 10'h003);
        en_req = 5'b00001; busy = 5'b00010;
        step(1);
        chk("b_iso", 10'(isolate), 10'h01e);
        chk("b_act", 10'(active), 10'h001);
        chk("b_clk_en_iso", 10'(clk_en), 10'h003);
        step(4);
        chk("b_clk_en_busy", 10'(clk_en), 10'h003);
        busy = 5'b00000;
        step(1);
        chk("b_clk_en_off", 10'(clk_en), 10'h001);
        chk("b_iso_off", 10'(isolate), 10'h01e);

        // Channel 1: busy low in the ISOLATE entry cycle must be ignored
        en_req = 5'b00011;
        step(5);
        chk("b2_act_on", 10'(active), 10'h003);
        en_req = 5'b00001;
        step(1);
        chk("b2_clk_en_entry", 10'(clk_en), 10'h003);
        step(1);
        chk("b2_clk_en_second", 10'(clk_en), 10'h003);
        step(1);
        chk("b2_clk_en_off", 10'(clk_en), 10'h001);

        // Channel 2 drain timeout
        en_req = 5'b00101;
        step(5);
        chk("c_act_on", 10'(active), 10'h005);
        busy = 5'b00100; en_req = 5'b00001;
        step(1);
        chk("c_iso_entry", 10'(isolate), 10'h01e);
        step(15);
        chk("c_iso_wait", 10'(isolate), 10'h01e);
        chk("c_err_wait", 10'(err), 10'h000);
        step(1);
`ifdef CHIMERA_CLKGATE_TIMEOUT_EN
        exp_iso = 5'b11010; exp_act = 5'b00101; exp_err = 5'b00100;
`else
        exp_iso = 5'b11110; exp_act = 5'b00001; exp_err = 5'b00000;
`endif
        chk("c_iso_timeout", 10'(isolate), 10'(exp_iso));
        chk("c_act_timeout", 10'(active), 10'(exp_act));
        chk("c_err_timeout", 10'(err), 10'(exp_err));
        chk("c_clk_en_timeout", 10'(clk_en), 10'h005);
        en_req = 5'b00101; err_clr = 5'b00100;
        step(1);
        chk("c_err_clr", 10'(err), 10'h000);
        chk("c_act_back", 10'(active), 10'h005);
        err_clr = 5'b00000;

        // Channel 2: clear coinciding with timeout leaves err set
        en_req = 5'b00001;
        step(1);
        step(15);
        err_clr = 5'b00100;
        step(1);
        chk("c2_err_setclr", 10'(err), 10'(exp_err));
        err_clr = 5'b00000; en_req = 5'b00101; busy = 5'b00000;
        step(1);
        chk("c2_act", 10'(active), 10'h005);
        chk("c2_err_hold", 10'(err), 10'(exp_err));
        err_clr = 5'b00100;
        step(1);
        chk("c2_err_clr", 10'(err), 10'h000);
        err_clr = 5'b00000;

        // Channel 3 request dropped during SETTLE cycle 2
        en_req = 5'b01101;
        step(1);
        chk("d_clk_en", 10'(clk_en), 10'h00d);
        step(1);
        chk("d_iso_settle", 10'(isolate), 10'h01a);
        en_req = 5'b00101;
        step(1);
        chk("d_clk_en_off", 10'(clk_en), 10'h005);
        chk("d_iso_off", 10'(isolate), 10'h01a);
        chk("d_act", 10'(active), 10'h005);

        // Channel 4 abort in the same cycle busy falls
        en_req = 5'b10101;
        step(5);
        chk("e_act_on", 10'(active), 10'h015);
        en_req = 5'b00101; busy = 5'b10000;
        step(1);
        chk("e_iso", 10'(isolate), 10'h01a);
        step(1);
        chk("e_clk_en_iso", 10'(clk_en), 10'h015);
        en_req = 5'b10101; busy = 5'b00000;
        step(1);
        chk("e_act_abort", 10'(active), 10'h015);
        chk("e_clk_en_abort", 10'(clk_en), 10'h015);
        chk("e_iso_abort", 10'(isolate), 10'h00a);

        // All channels ON and busy, then asynchronous reset between edges
        en_req = 5'b11111;
        step(5);
        chk("f_act_all", 10'(active), 10'h01f);
        chk("f_iso_all", 10'(isolate), 10'h000);
        busy = 5'b11111;
        step(1);
        #2 rst = 1'b1;
        #1;
        chk("f_rst_clk_en", 10'(clk_en), 10'h000);
        chk("f_rst_iso", 10'(isolate), 10'h01f);
        chk("f_rst_act", 10'(active), 10'h000);
        chk("f_rst_err", 10'(err), 10'h000);
        chk("f_rst_state", dbg_state, 10'h000);
        en_req = 5'b00000; busy = 5'b00000;
        step(2);
        rst = 1'b0;
        step(2);
        chk("f_post_clk_en", 10'(clk_en), 10'h000);
        en_req = 5'b00010;
        step(1);
        chk("f_first_req", 10'(clk_en), 10'h002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chimera_clu_clkgate_seq.md
CHIMERA_CLU_CLKGATE_SEQ -- requirements
Module: chimera_clu_clkgate_seq

Interface
REQ-001 SHALL have parameter ExtClusters, default 5: number of clusters sequenced, one independent channel per cluster.
REQ-002 SHALL have parameter SettleCycles, default 4 (range 1..255): cycles the clock runs with isolation held before release.
REQ-003 SHALL have parameter DrainTimeout, default 255 (range 2..65535): maximum cycles spent in ISOLATE waiting for drain.
REQ-004 soc_clk_i  input  1  SoC clock; all state on rising edge; one clock only.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 en_req_i  input  ExtClusters  requested cluster clock state from the control registers (1 = run).
REQ-007 busy_i  input  ExtClusters  cluster has outstanding narrow/wide AXI transactions.
REQ-008 err_clr_i  input  ExtClusters  clears the matching sticky err_o bit.
REQ-009 clk_en_o  output  ExtClusters  enable to the cluster clock gate producing clu_clk_i.
REQ-010 isolate_o  output  ExtClusters  AXI isolation request for the cluster's narrow and wide ports.
REQ-011 active_o  output  ExtClusters  channel is in ON.
REQ-012 err_o  output  ExtClusters  sticky drain-timeout flag.

Function
REQ-013 Each channel SHALL run an independent FSM with states OFF, SETTLE, ON, ISOLATE; all outputs SHALL be registered.
REQ-014 OFF: clk_en_o=0, isolate_o=1; en_req_i=1 sampled at edge k -> SETTLE, clk_en_o=1 from k+1.
REQ-015 SETTLE: clk_en_o=1, isolate_o=1; down-counter loaded with SettleCycles-1 on entry, decremented each cycle; at 0 -> ON, so isolate_o=0 and active_o=1 from k+1+SettleCycles.
REQ-016 SETTLE with en_req_i=0 SHALL return to OFF next cycle (clk_en_o=0), counter discarded.
REQ-017 ON: clk_en_o=1, isolate_o=0, active_o=1; en_req_i=0 at edge m -> ISOLATE, isolate_o=1 and active_o=0 from m+1.
REQ-018 ISOLATE: clk_en_o=1, isolate_o=1; busy_i SHALL be ignored in the entry cycle; from the second ISOLATE cycle, busy_i=0 -> OFF, clk_en_o=0 next cycle.
REQ-019 ISOLATE with en_req_i=1 SHALL return to ON next cycle (abort gating); this takes priority over drain completion.
REQ-020 Drain timeout (when compiled in): cycle counter starts at 1 on ISOLATE entry; if it reaches DrainTimeout with busy_i=1 -> ON, err_o set; counter saturates, never wraps.
REQ-021 err_o SHALL stay set until err_clr_i; simultaneous set and clear SHALL leave err_o set.
REQ-022 Channels SHALL not interact; simultaneous transitions on all channels SHALL be supported.
REQ-023 clk_en_o SHALL never fall while isolate_o is 0, and isolate_o SHALL never fall while clk_en_o is 0.

Reset
REQ-024 rst_i asserted at any time SHALL immediately force every channel to OFF: clk_en_o=0, isolate_o=all ones, active_o=0, err_o=0, counters 0.
REQ-025 After rst_i deasserts, the first transition SHALL occur at the first rising edge with en_req_i=1.

Configuration
REQ-026 Macro CHIMERA_CLKGATE_TIMEOUT_EN defined: drain timeout per REQ-020 included.
REQ-027 Macro undefined: ISOLATE waits indefinitely for busy_i=0, no timeout counter is built, and err_o SHALL be tied to 0 (err_clr_i ignored).

Verification
REQ-028 Reset, then en_req_i[0]=1 at edge 10 -> clk_en_o[0]=1 at 11, isolate_o[0]=0 and active_o[0]=1 at 15 (SettleCycles=4); other channels stay OFF.
REQ-029 ON, en_req_i[1]=0 at edge 20, busy_i[1]=1 until edge 25 -> isolate_o[1]=1 at 21, clk_en_o[1]=0 at 26.
REQ-030 Macro defined, DrainTimeout=16, busy_i[2] held 1 -> after 16 ISOLATE cycles channel 2 returns to ON, isolate_o[2]=0, err_o[2]=1; err_clr_i[2] pulse clears it. Same with macro undefined -> stays in ISOLATE, err_o=0.
REQ-031 en_req_i[3] drops during SETTLE cycle 2 -> OFF next cycle, clk_en_o[3]=0, isolate_o[3] never deasserted.
REQ-032 rst_i pulsed while all channels are in ON with busy_i=all ones -> all outputs reach reset values without waiting for a clock edge; REQ-023 assertion holds throughout the run.
REQ-033 en_req_i[4] re-asserted in ISOLATE in the same cycle busy_i[4] falls -> channel returns to ON, clk_en_o[4] stays 1.
